pwm_demodulator: RTL and testbench

PWM_DEMODULATOR -- requirements
Module: pwm_demodulator

---
 rtl/pwm_demodulator.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pwm_demodulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demodulator.sv
// PWM demodulator: frame-aligned duty measurement with lock tracking and a sampled output queue.
// Define PWM_DEMOD_FIFO_EN for a 4-entry output FIFO; otherwise a single overwrite register is used.
module pwm_demodulator #(
    parameter int DUTY_WIDTH  = 10,
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SAMPLE_FREQ = 8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_in,
    output logic [DUTY_WIDTH-1:0] duty,
    output logic                  duty_valid,
    output logic [DUTY_WIDTH-1:0] sample,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  locked,
    output logic                  lock_err,
    output logic                  overflow
);

    localparam int TICK_RAW    = CLK_FREQ / SAMPLE_FREQ;
    localparam int TICK_PERIOD = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
    localparam int HC_W = DUTY_WIDTH + 1;
    localparam logic [DUTY_WIDTH-1:0] FC_LAST = '1;
    localparam logic [1:0] MISS_LAST = 2'd3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic sync_meta_reg, sync_reg, sync_prev_reg;
    logic rise;

    logic [DUTY_WIDTH-1:0] fc_reg;
    logic [HC_W-1:0]       hc_reg;
    logic [HC_W-1:0]       hc_sum;
    logic                  rise_seen_reg;
    logic [1:0]            miss_reg;

    logic                  realign;
    logic                  relock;
    logic                  pos_zero;
    logic                  frame_end;
    logic                  frame_valid;
    logic                  frame_sat;
    logic                  frame_zero;
    logic                  miss_frame;
    logic                  lose_lock;
    logic                  lock_err_set;
    logic [DUTY_WIDTH-1:0] frame_duty;

    logic [DUTY_WIDTH-1:0] duty_reg;
    logic                  duty_valid_reg;
    logic                  have_duty_reg;
    logic                  lock_err_reg;
    logic                  overflow_reg;

    logic [TICK_W-1:0]     tick_cnt_reg;
    logic                  tick;
    logic [DUTY_WIDTH-1:0] push_data;
    logic                  pop;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
            sync_prev_reg <= 1'b0;
        end else begin
            sync_meta_reg <= pwm_in;
            sync_reg      <= sync_meta_reg;
            sync_prev_reg <= sync_reg;
        end
    end

    assign rise = sync_reg & ~sync_prev_reg;

    // A rise in HUNT always aligns; in LOCKED only a rise off position 0 does.
    assign relock       = (state_reg == HUNT) && rise;
    assign lock_err_set = (state_reg == LOCKED) && rise && (fc_reg != '0);
    assign realign      = relock || lock_err_set;
    assign pos_zero     = realign || (fc_reg == '0);
    assign frame_end    = !realign && (fc_reg == FC_LAST);

    assign hc_sum     = (pos_zero ? {HC_W{1'b0}} : hc_reg) + HC_W'(sync_reg);
    assign frame_sat  = hc_sum[DUTY_WIDTH];
    assign frame_zero = (hc_sum == '0);
    assign frame_duty = frame_sat ? {DUTY_WIDTH{1'b1}} : hc_sum[DUTY_WIDTH-1:0];

    assign frame_valid = (state_reg == LOCKED) && frame_end;
    // A constant level carries no edges but is still a legitimate duty.
    assign miss_frame  = frame_valid && !rise_seen_reg && !frame_sat && !frame_zero;
    assign lose_lock   = miss_frame && (miss_reg == MISS_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HUNT: begin
                if (rise) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (lose_lock) begin
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        locked = 1'b0;
        if (state_reg == LOCKED) begin
            locked = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fc_reg        <= '0;
            hc_reg        <= '0;
            rise_seen_reg <= 1'b0;
            miss_reg      <= '0;
        end else begin
            fc_reg        <= realign ? DUTY_WIDTH'(1) : fc_reg + 1'b1;
            hc_reg        <= hc_sum;
            rise_seen_reg <= pos_zero ? rise : (rise_seen_reg | rise);
            if ((state_reg != LOCKED) || rise) begin
                miss_reg <= '0;
            end else if (frame_valid) begin
                miss_reg <= miss_frame ? miss_reg + 1'b1 : 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            duty_reg       <= '0;
            duty_valid_reg <= 1'b0;
            have_duty_reg  <= 1'b0;
            lock_err_reg   <= 1'b0;
        end else begin
            duty_valid_reg <= frame_valid;
            lock_err_reg   <= lock_err_set;
            if (frame_valid) begin
                duty_reg <= frame_duty;
            end
            if (relock) begin
                have_duty_reg <= 1'b0;
            end else if (frame_valid) begin
                have_duty_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    assign tick = (tick_cnt_reg == TICK_LAST);

    // A frame finishing on the tick cycle wins over the older stored duty.
    always_comb begin
        push_data = '0;
        if (frame_valid) begin
            push_data = frame_duty;
        end else if (have_duty_reg && !relock) begin
            push_data = duty_reg;
        end
    end

    assign pop = sample_valid && sample_ready;

`ifdef PWM_DEMOD_FIFO_EN
    localparam logic [2:0] FIFO_DEPTH = 3'd4;

    logic [DUTY_WIDTH-1:0] fifo_mem [4];
    logic [1:0]            wr_ptr_reg;
    logic [1:0]            rd_ptr_reg;
    logic [2:0]            count_reg;
    logic                  fifo_full;
    logic                  push_accept;

    assign fifo_full   = (count_reg == FIFO_DEPTH);
    assign push_accept = tick && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_accept) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_accept, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (tick && !push_accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign sample_valid = (count_reg != '0);
    // Entries are not reset, so the head is masked until it holds data.
    assign sample       = sample_valid ? fifo_mem[rd_ptr_reg] : '0;
`else
    logic [DUTY_WIDTH-1:0] sample_reg;
    logic                  sample_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            overflow_reg     <= 1'b0;
        end else if (tick) begin
            sample_reg       <= push_data;
            sample_valid_reg <= 1'b1;
            if (sample_valid_reg && !pop) begin
                overflow_reg <= 1'b1;
            end
        end else if (pop) begin
            sample_valid_reg <= 1'b0;
        end
    end

    assign sample_valid = sample_valid_reg;
    assign sample       = sample_reg;
`endif

    assign duty       = duty_reg;
    assign duty_valid = duty_valid_reg;
    assign lock_err   = lock_err_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Directed bench for pwm_demodulator with a 16-clock frame and a tick every 64 clocks.
module tb_pwm_demodulator;

    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          pwm_in;
    logic [DW-1:0] duty;
    logic          duty_valid;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          locked;
    logic          lock_err;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pwm_demodulator #(
        .DUTY_WIDTH  (DW),
        .CLK_FREQ    (64),
        .SAMPLE_FREQ (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .locked       (locked),
        .lock_err     (lock_err),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One 16-clock frame high for n_high clocks; the previous frame's duty shows at i==1.
    task automatic frame(input int n_high, input logic exp_dv, input int exp_duty, input int err_idx);
        for (int i = 0; i < 16; i++) begin
            pwm_in = (i < n_high);
            clk1();
            if (i <= 2) chk("duty_valid", 32'(duty_valid), (i == 1) ? 32'(exp_dv) : 32'd0);
            if (i == 1 && exp_dv) chk("duty", 32'(duty), 32'(exp_duty));
            chk("lock_err", 32'(lock_err), 32'(i == err_idx));
            if (i == 15) chk("locked", 32'(locked), 32'd1);
        end
    endtask

    initial begin
        rst          = 1'b0;
        pwm_in       = 1'b0;
        sample_ready = 1'b0;
        repeat (3) clk1();
        chk("rst_duty", 32'(duty), 32'd0);
        chk("rst_duty_valid", 32'(duty_valid), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_lock_err", 32'(lock_err), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        rst = 1'b1;
        cyc = 0;
        for (int j = 0; j < 4; j++) begin
            pwm_in = 1'b0;
            clk1();
            chk("hunt_locked", 32'(locked), 32'd0);
            chk("hunt_duty_valid", 32'(duty_valid), 32'd0);
        end

        // First duty-5 frame: lock appears once the synchronized rise is seen.
        for (int i = 0; i < 16; i++) begin
            pwm_in = (i < 5);
            clk1();
            if (i == 1) chk("pre_lock", 32'(locked), 32'd0);
            if (i == 2) chk("lock_rise", 32'(locked), 32'd1);
            chk("lock_err_first", 32'(lock_err), 32'd0);
        end
        for (int k = 0; k < 3; k++) frame(5, 1'b1, 5, -1);

        // Constant high saturates at all-ones.
        frame(16, 1'b1, 5, -1);
        frame(16, 1'b1, 15, -1);
        frame(16, 1'b1, 15, -1);

        // Duty 3, then shift the phase by 7 clocks.
        frame(3, 1'b1, 15, -1);
        for (int j = 0; j < 7; j++) begin
            pwm_in = 1'b0;
            clk1();
            if (j <= 2) chk("dv_pre_shift", 32'(duty_valid), 32'(j == 1));
            if (j == 1) chk("duty_pre_shift", 32'(duty), 32'd3);
            chk("lock_err_pre_shift", 32'(lock_err), 32'd0);
        end
        frame(3, 1'b0, 0, 2);
        frame(3, 1'b1, 3, -1);

        // Held low: zero duty each frame, lock retained.
        frame(0, 1'b1, 3, -1);
        for (int k = 0; k < 5; k++) frame(0, 1'b1, 0, -1);

        for (int j = 0; j < 96; j++) begin
            pwm_in = 1'bx;
            clk1();
            if ((j % 32) == 31) chk("locked_x", 32'(locked), 32'd1);
        end

        // Reset mid-frame while the queue holds data.
        for (int j = 0; j < 24; j++) begin
            pwm_in = ((j % 16) < 5);
            clk1();
        end
        chk("pre_rst_sample_valid", 32'(sample_valid), 32'd1);
        chk("pre_rst_overflow", 32'(overflow), 32'd1);
        rst    = 1'b0;
        pwm_in = 1'b0;
        clk1();
        chk("mid_rst_duty", 32'(duty), 32'd0);
        chk("mid_rst_duty_valid", 32'(duty_valid), 32'd0);
        chk("mid_rst_sample", 32'(sample), 32'd0);
        chk("mid_rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_lock_err", 32'(lock_err), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        cyc = 0;

        // Relock at duty 9 and exercise the output queue across ticks at cycles 64, 128, ...
        for (int c = 0; c < 330; c++) begin
            pwm_in = ((c % 16) < 9);
            clk1();
            if (cyc == 1) begin
                chk("post_rst_dv", 32'(duty_valid), 32'd0);
                chk("post_rst_lock_err", 32'(lock_err), 32'd0);
            end
            if (cyc == 2) chk("relock_pre", 32'(locked), 32'd0);
            if (cyc == 3) chk("relock", 32'(locked), 32'd1);
            if (cyc == 18) begin
                chk("d9_dv", 32'(duty_valid), 32'd1);
                chk("d9_duty", 32'(duty), 32'd9);
            end
            if (cyc == 63) chk("pre_tick_valid", 32'(sample_valid), 32'd0);
            if (cyc == 64) begin
                chk("tick1_valid", 32'(sample_valid), 32'd1);
                chk("tick1_sample", 32'(sample), 32'd9);
                chk("tick1_overflow", 32'(overflow), 32'd0);
            end
`ifdef PWM_DEMOD_FIFO_EN
            if (cyc == 256) begin
                chk("tick4_overflow", 32'(overflow), 32'd0);
                chk("tick4_valid", 32'(sample_valid), 32'd1);
            end
            if (cyc == 320) begin
                chk("tick5_overflow", 32'(overflow), 32'd1);
                chk("tick5_sample", 32'(sample), 32'd9);
                sample_ready = 1'b1;
            end
            if (cyc >= 321 && cyc <= 323) begin
                chk("pop_valid", 32'(sample_valid), 32'd1);
                chk("pop_sample", 32'(sample), 32'd9);
            end
            if (cyc == 324) begin
                chk("drained", 32'(sample_valid), 32'd0);
                sample_ready = 1'b0;
            end
`else
            if (cyc == 128) begin
                chk("tick2_overflow", 32'(overflow), 32'd1);
                chk("tick2_sample", 32'(sample), 32'd9);
                sample_ready = 1'b1;
            end
            if (cyc == 129) begin
                chk("popped", 32'(sample_valid), 32'd0);
                sample_ready = 1'b0;
            end
`endif
            if (cyc == 329) begin
                chk("final_locked", 32'(locked), 32'd1);
                chk("final_lock_err", 32'(lock_err), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
